// File: rtl/aes_block_loader.sv
// aes_block_loader
// ----------------
// Sits in front of the iterative AES decrypt core. It collects 32-bit
// ciphertext words into 128-bit states, buffers DEPTH completed states in a
// small FIFO, and hands them to the core over a valid/ready block handshake.
// The first word of a group lands in bits [127:96] (big-endian word order).
//
// Ports
//   clk, rst_n  : single rising-edge clock, asynchronous active-low reset
//   clear       : synchronous flush of the partial group and of the FIFO
//   in_valid    : in_word carries a word
//   in_ready    : loader takes in_word on this edge when in_valid is high
//   in_word     : ciphertext word
//   out_valid   : out_block holds a complete state (FIFO not empty)
//   out_ready   : core takes out_block on this edge
//   out_block   : registered FIFO head
//   level       : number of complete states buffered
module aes_block_loader #(
    parameter int DEPTH = 2,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_word,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_block,
    output logic [LW-1:0] level
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          alive_q, alive_d;
    logic [1:0]    wcnt_q, wcnt_d;
    // Only words 0..2 need holding; word 3 goes straight into the FIFO.
    logic [95:0]   asm_q, asm_d;
    logic [127:0]  mem_q [DEPTH];
    logic [127:0]  mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [127:0]  head_q, head_d;

    logic accept;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // in_ready depends only on registered state, so there is no path from
    // out_ready; a pop in a full cycle frees the slot one cycle later.
    assign in_ready  = alive_q && ((wcnt_q != 2'd3) || (level_q < LW'(DEPTH)));
    assign out_valid = (level_q != '0);
    assign out_block = head_q;
    assign level     = level_q;

    assign accept = in_valid && in_ready && !clear;
    assign push   = accept && (wcnt_q == 2'd3);
    assign pop    = out_valid && out_ready && !clear;

    always_comb begin
        alive_d = 1'b1;
        wcnt_d  = wcnt_q;
        asm_d   = asm_q;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;

        if (clear) begin
            wcnt_d  = '0;
            asm_d   = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (accept) begin
                wcnt_d = wcnt_q + 2'd1;
                case (wcnt_q)
                    2'd0:    asm_d[95:64] = in_word;
                    2'd1:    asm_d[63:32] = in_word;
                    2'd2:    asm_d[31:0]  = in_word;
                    default: asm_d        = asm_q;
                endcase
            end
            if (push) begin
                mem_d[wptr_q] = {asm_q, in_word};
                wptr_d        = ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_d = ptr_inc(rptr_q);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end

        // Head register looks at the post-update storage so a block pushed
        // into an empty FIFO (or behind a pop at level 1) is visible right
        // after the edge that completed it.
        head_d = clear ? '0 : mem_d[rptr_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
            wcnt_q  <= '0;
            asm_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            head_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            alive_q <= alive_d;
            wcnt_q  <= wcnt_d;
            asm_q   <= asm_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            head_q  <= head_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule
